// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync/rgb, checks line and frame
// timing against the expected totals, acquires and holds lock, and produces a per-frame checksum
// of active pixels for loopback checking of the video generators.
module vga_timing_receiver #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [5:0]  rgb_in,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [5:0]  rgb_out,
   output logic        pix_valid,
   output logic        locked,
   output logic        timing_err,
   output logic [15:0] frame_sum,
   output logic        frame_sum_valid
);

   localparam logic [10:0] HStart     = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] HEnd       = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
   localparam logic [10:0] VStart     = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] VEnd       = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
   localparam logic [9:0]  HStart10   = 10'(H_SYNC + H_BACK);
   localparam logic [9:0]  VStart10   = 10'(V_SYNC + V_BACK);
   localparam logic [10:0] CntMax     = 11'h7FF;
   localparam logic [10:0] CntNearMax = 11'h7FE;
   localparam logic [11:0] HTotal     = 12'(H_TOTAL);
   localparam logic [11:0] VTotal     = 12'(V_TOTAL);
   localparam logic [2:0]  LockFrames = 3'(LOCK_FRAMES);

   typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

   logic        hs_q, hs_prev_q, vs_q, vs_prev_q;
   logic [5:0]  rgb_q, rgb_dly_q;
   logic        hs_edge, vs_edge, in_win;
   logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        vs_pend_q, vs_pend_d;
   state_e      state_q, state_d;
   logic [1:0]  good_q, good_d;
   logic        skip_q, skip_d;
   logic        err_seen_q, err_seen_d;
   logic        whole_q, whole_d;
   logic [15:0] acc_q, acc_d;
   logic        line_bad, frame_bad, timeout, err, sum_upd;

   // Input capture; rgb gets a second stage so it lines up with the counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q      <= 1'b0;
         hs_prev_q <= 1'b0;
         vs_q      <= 1'b0;
         vs_prev_q <= 1'b0;
         rgb_q     <= 6'd0;
         rgb_dly_q <= 6'd0;
      end else begin
         hs_q      <= hsync_in;
         hs_prev_q <= hs_q;
         vs_q      <= vsync_in;
         vs_prev_q <= vs_q;
         rgb_q     <= rgb_in;
         rgb_dly_q <= rgb_q;
      end
   end

   // Sync-assertion edges, counters, timing checks and checksum next-state.
   always_comb begin
      hs_edge = hs_prev_q & ~hs_q;
      vs_edge = vs_prev_q & ~vs_q;
      in_win  = (hcnt_q >= HStart) && (hcnt_q <= HEnd) && (vcnt_q >= VStart) && (vcnt_q <= VEnd);

      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      vs_pend_d = vs_pend_q | vs_edge;
      if (hs_edge) begin
         hcnt_d    = 11'd0;
         vs_pend_d = 1'b0;
         if (vs_edge || vs_pend_q) begin
            vcnt_d = 11'd0;
         end else if (vcnt_q != CntMax) begin
            vcnt_d = vcnt_q + 11'd1;
         end
      end else if (hcnt_q != CntMax) begin
         hcnt_d = hcnt_q + 11'd1;
      end

      line_bad  = hs_edge && (({1'b0, hcnt_q} + 12'd1) != HTotal) &&
                  (state_q != StSearch) && !skip_q;
      frame_bad = vs_edge && (({1'b0, vcnt_q} + 12'd1) != VTotal) && (state_q != StSearch);
      timeout   = (hcnt_q == CntNearMax) && !hs_edge && (state_q != StSearch);
      err       = line_bad | frame_bad | timeout;

      // The first line after leaving SEARCH started before we were aligned; don't judge it.
      skip_d = skip_q;
      if (hs_edge) begin
         skip_d = 1'b0;
      end
      if ((state_q == StSearch) && vs_edge && !hs_edge) begin
         skip_d = 1'b1;
      end

      err_seen_d = vs_edge ? 1'b0 : (err_seen_q | err);
      acc_d      = vs_edge ? 16'd0 : (acc_q + (in_win ? {10'd0, rgb_dly_q} : 16'd0));
   end

   // Lock FSM next-state, plus the "locked for the whole frame" qualifier for the checksum.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      case (state_q)
         StSearch: begin
            if (vs_edge) begin
               state_d = StAcquire;
               good_d  = 2'd0;
            end
         end
         StAcquire: begin
            if (timeout) begin
               state_d = StSearch;
               good_d  = 2'd0;
            end else if (err) begin
               good_d = 2'd0;
            end else if (vs_edge && !err_seen_q) begin
               good_d = good_q + 2'd1;
               if (({1'b0, good_q} + 3'd1) >= LockFrames) begin
                  state_d = StLocked;
               end
            end
         end
         StLocked: begin
            if (timeout) begin
               state_d = StSearch;
               good_d  = 2'd0;
            end else if (err) begin
               state_d = StAcquire;
               good_d  = 2'd0;
            end
         end
         default: begin
            state_d = StSearch;
            good_d  = 2'd0;
         end
      endcase

      whole_d = whole_q;
      if (state_d != StLocked) begin
         whole_d = 1'b0;
      end else if (vs_edge) begin
         whole_d = 1'b1;
      end

      sum_upd = vs_edge && (state_q == StLocked) && whole_q && !err && !err_seen_q;
   end

   // Counter, FSM and checksum state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q     <= 11'd0;
         vcnt_q     <= 11'd0;
         vs_pend_q  <= 1'b0;
         state_q    <= StSearch;
         good_q     <= 2'd0;
         skip_q     <= 1'b0;
         err_seen_q <= 1'b0;
         whole_q    <= 1'b0;
         acc_q      <= 16'd0;
      end else begin
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         vs_pend_q  <= vs_pend_d;
         state_q    <= state_d;
         good_q     <= good_d;
         skip_q     <= skip_d;
         err_seen_q <= err_seen_d;
         whole_q    <= whole_d;
         acc_q      <= acc_d;
      end
   end

   // Output stage: pixel data holds outside the active window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_x           <= 10'd0;
         pix_y           <= 10'd0;
         rgb_out         <= 6'd0;
         pix_valid       <= 1'b0;
         locked          <= 1'b0;
         timing_err      <= 1'b0;
         frame_sum       <= 16'd0;
         frame_sum_valid <= 1'b0;
      end else begin
         if (in_win) begin
            pix_x   <= hcnt_q[9:0] - HStart10;
            pix_y   <= vcnt_q[9:0] - VStart10;
            rgb_out <= rgb_dly_q;
         end
         pix_valid       <= in_win && (state_q == StLocked);
         locked          <= (state_d == StLocked);
         timing_err      <= err;
         frame_sum_valid <= sum_upd;
         if (sum_upd) begin
            frame_sum <= acc_q;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver using a scaled-down 32x14 raster (16x6 active) so whole
// frames stay short. The 11-bit line timeout is unscaled.
module tb_vga_timing_receiver;

   localparam int HS = 4, HB = 4, HA = 16, HT = 32;
   localparam int VS = 2, VB = 3, VA = 6, VT = 14;

   logic        clk = 1'b0;
   logic        rst_n, hsync_in, vsync_in;
   logic [5:0]  rgb_in;
   logic [9:0]  pix_x, pix_y;
   logic [5:0]  rgb_out;
   logic        pix_valid, locked, timing_err, frame_sum_valid;
   logic [15:0] frame_sum;

   int   errors = 0;
   int   checks = 0;
   int   n_err, n_fsv, n_valid, bad_pat;
   bit   seen_first, pat_mode;
   logic [9:0] first_x, first_y;

   always #5 clk = ~clk;

   vga_timing_receiver #(
      .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
      .pix_x(pix_x), .pix_y(pix_y), .rgb_out(rgb_out), .pix_valid(pix_valid),
      .locked(locked), .timing_err(timing_err), .frame_sum(frame_sum),
      .frame_sum_valid(frame_sum_valid)
   );

   task automatic clr();
      n_err = 0; n_fsv = 0; n_valid = 0; bad_pat = 0; seen_first = 1'b0;
   endtask

   // One pixel clock: drive inputs, then tally output events just after the edge.
   task automatic cyc(input logic hs, input logic vs, input logic [5:0] rgb);
      hsync_in = hs; vsync_in = vs; rgb_in = rgb;
      @(posedge clk); #1;
      if (timing_err) n_err++;
      if (frame_sum_valid) n_fsv++;
      if (pix_valid) begin
         n_valid++;
         if (!seen_first) begin
            seen_first = 1'b1; first_x = pix_x; first_y = pix_y;
         end
         if (pat_mode && (rgb_out !== pix_x[5:0])) bad_pat++;
      end
   endtask

   // Generate one frame (optionally a slice of it by linear cycle index).
   task automatic gen_frame(input int lines, input int bad_line, input bit pat,
                            input int first_idx, input int last_idx);
      int idx = 0;
      int len;
      logic [5:0] px;
      pat_mode = pat;
      for (int y = 0; y < lines; y++) begin
         len = (y == bad_line) ? HT - 1 : HT;
         for (int x = 0; x < len; x++) begin
            if (idx >= first_idx && (last_idx < 0 || idx < last_idx)) begin
               if (x >= HS + HB && x < HS + HB + HA && y >= VS + VB && y < VS + VB + VA)
                  px = pat ? 6'(x - (HS + HB)) : 6'h3F;
               else
                  px = 6'd0;
               cyc(x >= HS, y >= VS, px);
            end
            idx++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pix_x, pix_y, rgb_out, pix_valid, locked, timing_err, frame_sum, frame_sum_valid} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: x=%0d y=%0d rgb=%h v=%b l=%b e=%b sum=%h sv=%b required all 0",
                  pix_x, pix_y, rgb_out, pix_valid, locked, timing_err, frame_sum, frame_sum_valid);
      end
   endtask

   task automatic test_acquire();
      rst_n = 1'b1;
      clr();
      gen_frame(VT, -1, 1'b0, 7 * HT + 13, -1);
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL acq_f1_locked: got %b required 0", locked); end
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL acq_f2_locked: got %b required 0", locked); end
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL acq_f3_locked: got %b required 1", locked); end
      checks++;
      if (n_err !== 0) begin errors++; $display("FAIL acq_no_err: got %0d pulses required 0", n_err); end
      clr();
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (n_fsv !== 1) begin errors++; $display("FAIL acq_fsv: got %0d pulses required 1", n_fsv); end
      checks++;
      if (frame_sum !== 16'h17A0) begin errors++; $display("FAIL acq_sum: got %h required 17a0", frame_sum); end
      checks++;
      if (n_valid !== 96) begin errors++; $display("FAIL acq_valid_cnt: got %0d required 96", n_valid); end
      checks++;
      if (n_err !== 0) begin errors++; $display("FAIL acq_f4_err: got %0d required 0", n_err); end
   endtask

   task automatic test_pattern();
      clr();
      gen_frame(VT, -1, 1'b1, 0, -1);
      checks++;
      if (n_valid !== 96) begin errors++; $display("FAIL pat_valid_cnt: got %0d required 96", n_valid); end
      checks++;
      if (first_x !== 10'd0) begin errors++; $display("FAIL pat_first_x: got %0d required 0", first_x); end
      checks++;
      if (first_y !== 10'd0) begin errors++; $display("FAIL pat_first_y: got %0d required 0", first_y); end
      checks++;
      if (bad_pat !== 0) begin errors++; $display("FAIL pat_rgb_align: got %0d bad required 0", bad_pat); end
      clr();
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (n_fsv !== 1) begin errors++; $display("FAIL pat_fsv: got %0d required 1", n_fsv); end
      checks++;
      if (frame_sum !== 16'h02D0) begin errors++; $display("FAIL pat_sum: got %h required 02d0", frame_sum); end
   endtask

   task automatic test_short_line();
      clr();
      gen_frame(VT, 7, 1'b0, 0, -1);
      checks++;
      if (n_err !== 1) begin errors++; $display("FAIL sl_err: got %0d pulses required 1", n_err); end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL sl_locked: got %b required 0", locked); end
      clr();
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (n_fsv !== 0) begin errors++; $display("FAIL sl_no_fsv: got %0d required 0", n_fsv); end
      checks++;
      if (n_err !== 0) begin errors++; $display("FAIL sl_clean_err: got %0d required 0", n_err); end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL sl_f8_locked: got %b required 0", locked); end
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL sl_f9_locked: got %b required 0", locked); end
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL sl_relock: got %b required 1", locked); end
   endtask

   task automatic test_short_frame();
      clr();
      gen_frame(VT - 1, -1, 1'b1, 0, -1);
      checks++;
      if (n_fsv !== 1) begin errors++; $display("FAIL sf_prev_fsv: got %0d required 1", n_fsv); end
      checks++;
      if (frame_sum !== 16'h17A0) begin errors++; $display("FAIL sf_prev_sum: got %h required 17a0", frame_sum); end
      clr();
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (n_err !== 1) begin errors++; $display("FAIL sf_err: got %0d required 1", n_err); end
      checks++;
      if (n_fsv !== 0) begin errors++; $display("FAIL sf_no_fsv: got %0d required 0", n_fsv); end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL sf_locked: got %b required 0", locked); end
      checks++;
      if (frame_sum !== 16'h17A0) begin errors++; $display("FAIL sf_sum_hold: got %h required 17a0", frame_sum); end
   endtask

   task automatic test_timeout();
      clr();
      pat_mode = 1'b0;
      repeat (2100) cyc(1'b1, 1'b1, 6'd0);
      checks++;
      if (n_err !== 1) begin errors++; $display("FAIL to_err: got %0d required 1", n_err); end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL to_locked: got %b required 0", locked); end
      clr();
      gen_frame(VT, -1, 1'b0, 0, -1);
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL to_f2_locked: got %b required 0", locked); end
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL to_relock: got %b required 1", locked); end
      checks++;
      if (n_err !== 0) begin errors++; $display("FAIL to_relock_err: got %0d required 0", n_err); end
   endtask

   task automatic test_async_reset();
      gen_frame(VT, -1, 1'b0, 0, 7 * HT + 12);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL ar_pre_locked: got %b required 1", locked); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pix_x, pix_y, rgb_out, pix_valid, locked, timing_err, frame_sum, frame_sum_valid} !== '0) begin
         errors++;
         $display("FAIL ar_outputs: x=%0d y=%0d rgb=%h v=%b l=%b e=%b sum=%h sv=%b required all 0",
                  pix_x, pix_y, rgb_out, pix_valid, locked, timing_err, frame_sum, frame_sum_valid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clr();
      gen_frame(VT, -1, 1'b0, 7 * HT + 13, -1);
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL ar_f1_locked: got %b required 0", locked); end
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL ar_f2_locked: got %b required 0", locked); end
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL ar_f3_locked: got %b required 1", locked); end
      checks++;
      if (n_err !== 0) begin errors++; $display("FAIL ar_err: got %0d required 0", n_err); end
      clr();
      gen_frame(VT, -1, 1'b0, 0, -1);
      checks++;
      if (n_fsv !== 1) begin errors++; $display("FAIL ar_fsv: got %0d required 1", n_fsv); end
      checks++;
      if (frame_sum !== 16'h17A0) begin errors++; $display("FAIL ar_sum: got %h required 17a0", frame_sum); end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_pattern();
      test_short_line();
      test_short_frame();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Receive end of the VGA output interface: samples hsync, vsync and 6-bit RGB from the display pipeline.
- Recovers pixel coordinates, checks 640x480@60 timing, acquires/holds lock and produces a per-frame pixel checksum.
- Used as an on-chip loopback checker for the video generators. Same clock domain as the generator (pixel clock).

Parameters:
H_ACTIVE, 640, active pixels per line
H_SYNC, 96, hsync pulse width (cycles)
H_BACK, 48, back porch (cycles)
H_TOTAL, 800, expected cycles per line
V_ACTIVE, 480, active lines per frame
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, back porch (lines)
V_TOTAL, 525, expected lines per frame
LOCK_FRAMES, 2, consecutive good frames required to lock (1..3)

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset, asynchronous, active-low
hsync_in  input  1  horizontal sync, active-low
vsync_in  input  1  vertical sync, active-low
rgb_in  input  6  {R[1:0],G[1:0],B[1:0]}
pix_x  output  10  recovered column, 0..639
pix_y  output  10  recovered row, 0..479
rgb_out  output  6  rgb aligned to pix_x/pix_y
pix_valid  output  1  high for active pixels while locked
locked  output  1  timing lock status
timing_err  output  1  one-cycle pulse on any timing violation
frame_sum  output  16  checksum of last completed locked frame
frame_sum_valid  output  1  one-cycle pulse when frame_sum updates

Behaviour:
- Reset (async, rst_n low): all outputs 0, all counters 0, state SEARCH. Reset mid-frame discards partial measurements; reacquire from scratch.
- Stage 1: register hsync_in, vsync_in, rgb_in. Edge detect on registered values; "hs edge" = 1->0, "vs edge" = 1->0 (sync assertion).
- hcnt (11 bit): cleared to 0 on hs edge cycle, else +1, saturates at 2047.
- vcnt (11 bit): +1 on each hs edge; cleared to 0 on an hs edge coinciding with or following a vs edge (first line after vs edge is line 0). Saturates at 2047.
- Active window: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1]. pix_x = hcnt-(H_SYNC+H_BACK), pix_y = vcnt-(V_SYNC+V_BACK), truncated to 10 bits.
- Stage 2: pix_x, pix_y, rgb_out, pix_valid registered. Latency: rgb_in sampled at edge N appears on rgb_out at edge N+2. pix_valid = in-window AND state==LOCKED. Outside the window, pix_x/pix_y/rgb_out hold last values.
- Line check at each hs edge (except the first after entering ACQUIRE): line length = hcnt+1 must equal H_TOTAL, else line error.
- Frame check at each vs edge: lines counted must equal V_TOTAL, else frame error.
- Timeout: hcnt reaching 2047 = line error.
- States:
  - SEARCH: wait for vs edge -> ACQUIRE, good=0.
  - ACQUIRE: on vs edge with no error in closing frame, good+1; when good reaches LOCK_FRAMES -> LOCKED. Any line/frame error -> good=0, stay in ACQUIRE. Timeout -> SEARCH.
  - LOCKED: any error -> ACQUIRE with good=0; timeout -> SEARCH.
- locked = registered (state==LOCKED); asserts the cycle after the qualifying vs edge is registered.
- timing_err pulses one cycle per detected error in ACQUIRE or LOCKED. Errors are not reported in SEARCH. Simultaneous line and frame errors give a single pulse.
- Checksum: 16-bit accumulator, += zero-extended rgb of each in-window pixel, modulo 2^16. Cleared on vs edge.
- frame_sum/frame_sum_valid: on a vs edge, if state was LOCKED for the whole closing frame and no error occurred, frame_sum <= accumulator and frame_sum_valid pulses. Otherwise frame_sum holds and there is no pulse.
- Simultaneous hs and vs edge: both processed in the same cycle. The line check uses the old hcnt; vcnt clears.

Test Plan:
- Nominal 800x525 generator, rgb=6'h3F constant, rst released mid-line -> locked asserts after 3rd vs edge (LOCKED_FRAMES=2). Next frame: frame_sum=16'h5000, frame_sum_valid one pulse, timing_err never.
- Locked, rgb = pix_x[5:0] pattern -> every pix_valid cycle rgb_out equals pix_x[5:0]. Exactly 307200 pix_valid cycles per frame; first valid pix_x=0,pix_y=0.
- Locked, inject one 799-cycle line -> one timing_err pulse, locked drops, no frame_sum_valid that frame, relock after 2 further clean frames.
- Locked, 524-line frame -> timing_err pulse at that vs edge, locked=0, frame_sum unchanged.
- Hold hsync_in high >2047 cycles -> timing_err, state SEARCH, locked=0. Resume nominal -> relock after 3 vs edges.
- Assert rst_n low for 1 cycle mid-active-line while locked -> all outputs 0 immediately (async), then reacquisition as in scenario 1.
